// File: rtl/exp7_sequenciador_leds_if.sv
// Control/memory bundle between the game control unit, the sequence memory and the LED
// playback sequencer.
interface exp7_sequenciador_leds_if;
  logic       iniciar;
  logic       cancelar;
  logic [3:0] limite;
  logic [3:0] dado_mem;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       ocupado;
  logic       fim;
  logic [3:0] db_estado;

  modport master (
    output iniciar, cancelar, limite, dado_mem,
    input  endereco, leds, ocupado, fim, db_estado
  );

  modport slave (
    input  iniciar, cancelar, limite, dado_mem,
    output endereco, leds, ocupado, fim, db_estado
  );
endinterface

// File: rtl/exp7_sequenciador_leds.sv
// Memory-game playback sequencer: walks addresses 0..limite, lighting each stored pattern for
// T_ON cycles and blanking for T_OFF cycles, then pulses fim.
module exp7_sequenciador_leds #(
  parameter int unsigned T_ON  = 500,
  parameter int unsigned T_OFF = 250
) (
  input logic                     clock,
  input logic                     reset,
  exp7_sequenciador_leds_if.slave bus
);

  localparam int unsigned TMax = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int unsigned TW   = $clog2(TMax) + 1;
  localparam logic [TW-1:0] TOnLast  = TW'(T_ON - 1);
  localparam logic [TW-1:0] TOffLast = TW'(T_OFF - 1);

  typedef enum logic [2:0] {
    StOcioso  = 3'd0,
    StCarrega = 3'd1,
    StAcende  = 3'd2,
    StApaga   = 3'd3,
    StAvanca  = 3'd4,
    StConclui = 3'd5
  } estado_e;

  estado_e       estado_q;
  logic [3:0]    endereco_q;
  logic [3:0]    lim_q;
  logic [TW-1:0] timer_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= StOcioso;
      endereco_q <= '0;
      lim_q      <= '0;
      timer_q    <= '0;
    end else if (bus.cancelar) begin
      // Abort wins over everything else, including a simultaneous iniciar.
      estado_q   <= StOcioso;
      endereco_q <= '0;
      timer_q    <= '0;
    end else begin
      case (estado_q)
        StOcioso: begin
          endereco_q <= '0;
          if (bus.iniciar) begin
            lim_q    <= bus.limite;
            estado_q <= StCarrega;
          end
        end
        StCarrega: begin
          timer_q    <= '0;
          endereco_q <= '0;
          estado_q   <= StAcende;
        end
        StAcende: begin
          if (timer_q == TOnLast) begin
            timer_q  <= '0;
            estado_q <= StApaga;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StApaga: begin
          if (timer_q == TOffLast) begin
            timer_q  <= '0;
            estado_q <= (endereco_q == lim_q) ? StConclui : StAvanca;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StAvanca: begin
          endereco_q <= endereco_q + 4'd1;
          timer_q    <= '0;
          estado_q   <= StAcende;
        end
        StConclui: begin
          endereco_q <= '0;
          estado_q   <= StOcioso;
        end
        default: begin
          estado_q   <= StOcioso;
          endereco_q <= '0;
          timer_q    <= '0;
        end
      endcase
    end
  end

  assign bus.endereco = endereco_q;

  // Moore decode; leds passes memory data through live while lit.
  always_comb begin
    bus.leds      = '0;
    bus.ocupado   = 1'b1;
    bus.fim       = 1'b0;
    bus.db_estado = 4'd9;
    case (estado_q)
      StOcioso: begin
        bus.ocupado   = 1'b0;
        bus.db_estado = 4'd0;
      end
      StCarrega: bus.db_estado = 4'd1;
      StAcende: begin
        bus.leds      = bus.dado_mem;
        bus.db_estado = 4'd2;
      end
      StApaga:  bus.db_estado = 4'd3;
      StAvanca: bus.db_estado = 4'd4;
      StConclui: begin
        bus.fim       = 1'b1;
        bus.db_estado = 4'd5;
      end
      default:  bus.ocupado = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_exp7_sequenciador_leds.sv
// Bench for the LED playback sequencer: a timeline model derived from the run start cycle
// checks every cycle, plus directed literal checks for the listed scenarios.
module tb_exp7_sequenciador_leds;

  localparam int TON  = 4;
  localparam int TOFF = 2;
  localparam int PER  = TON + TOFF + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  exp7_sequenciador_leds_if bus();

  logic [3:0] rom [16];
  assign bus.dado_mem = rom[bus.endereco];

  exp7_sequenciador_leds #(
    .T_ON  (TON),
    .T_OFF (TOFF)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cur      = 0;

  // Model: busy flag, cycle index t relative to the accepted iniciar, latched limit.
  bit m_busy  = 1'b0;
  int m_t     = 0;
  int m_l     = 0;
  bit started = 1'b0;

  function automatic int fim_cycle(input int l);
    return 2 + (l + 1) * (TON + TOFF) + l;
  endfunction

  always @(posedge clock) begin
    started <= 1'b1;
    if (reset || bus.cancelar) begin
      m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (bus.iniciar) begin
        m_busy <= 1'b1;
        m_t    <= 1;
        m_l    <= int'(bus.limite);
      end
    end else if (m_t == fim_cycle(m_l)) begin
      m_busy <= 1'b0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_out(input bit b, input int t, input int l,
                           output int e_leds, output int e_end, output int e_est,
                           output int e_ocup, output int e_fim);
    int u, k, r;
    e_leds = 0; e_end = 0; e_est = 0; e_ocup = 0; e_fim = 0;
    if (b) begin
      e_ocup = 1;
      if (t == 1) begin
        e_est = 1;
      end else begin
        u = t - 2;
        k = u / PER;
        r = u % PER;
        e_end = k;
        if (r < TON) begin
          e_est  = 2;
          e_leds = int'(rom[k]);
        end else if (r < TON + TOFF) begin
          e_est = 3;
        end else if (k == l) begin
          e_est = 5;
          e_fim = 1;
        end else begin
          e_est = 4;
        end
      end
    end
  endtask

  always @(negedge clock) begin
    int e_leds, e_end, e_est, e_ocup, e_fim;
    if (started) begin
      model_out(m_busy, m_t, m_l, e_leds, e_end, e_est, e_ocup, e_fim);
      check("model_leds", int'(bus.leds), e_leds);
      check("model_endereco", int'(bus.endereco), e_end);
      check("model_db_estado", int'(bus.db_estado), e_est);
      check("model_ocupado", int'(bus.ocupado), e_ocup);
      check("model_fim", int'(bus.fim), e_fim);
    end
  end

  task automatic step();
    @(negedge clock);
    cur++;
  endtask

  task automatic goto_cycle(input int n);
    while (cur < n) step();
  endtask

  // Called at a negedge while idle; returns at the negedge of cycle 1.
  task automatic start_run(input int l);
    bus.limite  = 4'(l);
    bus.iniciar = 1'b1;
    cur = 0;
    step();
    bus.iniciar = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'(1 << (i % 4));
    bus.iniciar  = 1'b0;
    bus.cancelar = 1'b0;
    bus.limite   = 4'd0;

    repeat (2) @(negedge clock);
    check("reset_db_estado", int'(bus.db_estado), 0);
    check("reset_ocupado", int'(bus.ocupado), 0);
    check("reset_leds", int'(bus.leds), 0);
    reset = 1'b0;
    @(negedge clock);

    // Nominal run, L=2
    start_run(2);
    goto_cycle(2);  check("nom_leds_c2", int'(bus.leds), 1);
    goto_cycle(7);  check("nom_leds_c7", int'(bus.leds), 0);
    goto_cycle(9);  check("nom_leds_c9", int'(bus.leds), 2);
    goto_cycle(16); check("nom_leds_c16", int'(bus.leds), 4);
    goto_cycle(21); check("nom_fim_c21", int'(bus.fim), 0);
    goto_cycle(22); check("nom_fim_c22", int'(bus.fim), 1);
    goto_cycle(23); check("nom_fim_c23", int'(bus.fim), 0);
    check("nom_end_c23", int'(bus.endereco), 0);
    check("nom_ocup_c23", int'(bus.ocupado), 0);

    // Single entry
    start_run(0);
    goto_cycle(5); check("one_leds_c5", int'(bus.leds), 1);
    goto_cycle(8); check("one_fim_c8", int'(bus.fim), 1);
    check("one_end_c8", int'(bus.endereco), 0);
    goto_cycle(9);

    // Full depth
    start_run(15);
    goto_cycle(107); check("full_end_c107", int'(bus.endereco), 15);
    check("full_leds_c107", int'(bus.leds), 8);
    goto_cycle(113); check("full_fim_c113", int'(bus.fim), 1);
    goto_cycle(114);

    // Abort in cycle 10
    start_run(2);
    goto_cycle(10);
    bus.cancelar = 1'b1;
    step();
    bus.cancelar = 1'b0;
    check("abort_ocup_c11", int'(bus.ocupado), 0);
    check("abort_leds_c11", int'(bus.leds), 0);
    check("abort_end_c11", int'(bus.endereco), 0);
    goto_cycle(25);

    // iniciar with a new limite while busy is ignored
    start_run(2);
    goto_cycle(3);
    bus.iniciar = 1'b1;
    bus.limite  = 4'd5;
    step();
    bus.iniciar = 1'b0;
    bus.limite  = 4'd0;
    goto_cycle(22); check("busy_fim_c22", int'(bus.fim), 1);
    goto_cycle(23);

    // Reset mid-run
    start_run(2);
    goto_cycle(7);
    reset = 1'b1;
    step();
    check("rst_db_estado", int'(bus.db_estado), 0);
    check("rst_end", int'(bus.endereco), 0);
    check("rst_ocup", int'(bus.ocupado), 0);
    reset = 1'b0;
    step();

    // iniciar and cancelar together in ocioso
    bus.iniciar  = 1'b1;
    bus.cancelar = 1'b1;
    step();
    bus.iniciar  = 1'b0;
    bus.cancelar = 1'b0;
    check("both_ocup", int'(bus.ocupado), 0);
    check("both_db_estado", int'(bus.db_estado), 0);
    step();

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      bus.iniciar  = ($urandom_range(0, 7) == 0);
      bus.cancelar = ($urandom_range(0, 149) == 0);
      bus.limite   = 4'($urandom_range(0, 15));
      reset        = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;
    bus.iniciar  = 1'b0;
    bus.cancelar = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exp7_sequenciador_leds.md
# exp7_sequenciador_leds

Playback sequencer for the memory game: on a start pulse it walks the sequence memory from address 0 up to a latched limit. Each stored pattern is shown on the LEDs for T_ON cycles, then the LEDs are blanked for T_OFF cycles. A one-cycle completion pulse follows the last entry. It owns the playback address and the on/off timing, so the game control unit only issues `iniciar` and waits for `fim`.

## Interface
- T_ON, default 500: cycles each pattern is lit; must be ≥1.
- T_OFF, default 250: blank cycles after each pattern; must be ≥1.
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; one clock and reset domain.
- iniciar  in  1  start request; sampled only in `ocioso`.
- cancelar  in  1  abort; forces return to `ocioso`, no `fim`.
- limite  in  4  index of last entry to show, inclusive; latched on accepted `iniciar`.
- dado_mem  in  4  memory read data; combinational read, valid in the same cycle as `endereco`.
- endereco  out  4  playback address to sequence memory (registered).
- leds  out  4  pattern shown to player.
- ocupado  out  1  high in every state except `ocioso`.
- fim  out  1  one-cycle pulse, playback complete.
- db_estado  out  4  debug state code.

## Operation
- States and db_estado codes: ocioso=0, carrega=1, acende=2, apaga=3, avanca=4, conclui=5; any illegal state → `ocioso`, code 9.
- ocioso:
  - Address held at 0.
  - On `iniciar`=1, latch `limite` into lim_reg and go to carrega.
- carrega: one cycle; clear timer and address → acende.
- acende:
  - leds=dado_mem.
  - Timer increments; when timer==T_ON-1, clear timer → apaga.
- apaga:
  - leds=0.
  - Timer increments; when timer==T_OFF-1, clear timer.
  - If endereco==lim_reg → conclui, else → avanca.
- avanca: endereco+1, timer held at 0 → acende.
- conclui: fim=1 → ocioso; endereco returns to 0 on the next edge.
- leds=0 in every state other than acende; leds follows dado_mem live while in acende.
- Timer width is ceil(log2(max(T_ON,T_OFF)))+1 bits. Address arithmetic is 4-bit.
- endereco never wraps, because playback stops at lim_reg ≤ 15. lim_reg=15 shows 16 entries.
- Boundary cases:
  - `iniciar` while ocupado: ignored; limite is not re-latched.
  - `limite` changes mid-playback: no effect.
  - `cancelar` and `iniciar` in the same cycle in ocioso: cancelar wins and the block stays in ocioso.
  - `cancelar` in any state: next state ocioso, endereco←0, timer←0, no fim pulse.
  - `cancelar` in conclui: fim is still high that cycle, because it is a Moore output.
  - `reset` mid-operation: same effect as cancelar, and overrides every input.

## Timing
- Reset values: state ocioso, endereco=0, leds=0, ocupado=0, fim=0, db_estado=0, lim_reg=0, timer=0.
- fim, ocupado, leds and db_estado are Moore outputs decoded from the current state; fim is high for exactly 1 cycle.
- Let cycle 0 be the cycle where `iniciar` is sampled in ocioso, and L=lim_reg.
  - Cycle 1 is carrega.
  - Entry k (0..L) is lit for T_ON cycles starting at cycle 2+k·(T_ON+T_OFF+1).
  - fim is high in cycle 2+(L+1)(T_ON+T_OFF)+L.
  - ocupado is high from cycle 1 through the fim cycle inclusive.
- endereco becomes k+1 on the edge leaving avanca, so dado_mem for the new entry is valid in the first acende cycle.
- A new `iniciar` is accepted in the first ocioso cycle after conclui. Minimum gap from fim to the next carrega is 2 cycles.

## Test plan
- Nominal run (T_ON=4, T_OFF=2, ROM=1,2,4,8):
  - Stimulus: reset, then iniciar for 1 cycle with limite=2.
  - Expected: leds=1 in cycles 2-5, 0 in 6-7, 2 in 9-12, 4 in 16-19; fim only in cycle 22; endereco=0 afterwards.
- Single entry:
  - Stimulus: limite=0.
  - Expected: one lit window in cycles 2-5, fim in cycle 8, endereco never leaves 0.
- Full depth:
  - Stimulus: limite=15.
  - Expected: 16 lit windows, endereco reaches 15 without wrapping, fim in cycle 2+16·6+15=113.
- Abort mid-run:
  - Stimulus: cancelar in cycle 10 of a nominal run.
  - Expected: ocioso, ocupado=0, leds=0 and endereco=0 from cycle 11; fim never pulses.
- Busy and reset:
  - Stimulus A: iniciar with limite=5 during acende.
    - Expected: ignored, run still ends with L=2 timing.
  - Stimulus B: reset in cycle 7.
    - Expected: all outputs at reset values after the next edge.
  - Stimulus C: iniciar and cancelar together in ocioso.
    - Expected: stays in ocioso.
